// File: rtl/msg_counter_bank_if.sv
// Bus bundle for msg_counter_bank: increment, force, freshness check, read and overflow status.
// The master drives the requests; the slave (the counter bank) returns results.
interface msg_counter_bank_if #(
  parameter int CNTR_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2
);
  logic                  inc_en;
  logic [CH_W-1:0]       inc_ch;
  logic                  force_en;
  logic [CH_W-1:0]       force_ch;
  logic [CNTR_WIDTH-1:0] force_value;
  logic                  chk_valid;
  logic [CH_W-1:0]       chk_ch;
  logic [CNTR_WIDTH-1:0] chk_value;
  logic                  chk_done;
  logic                  chk_accept;
  logic [CH_W-1:0]       rd_ch;
  logic [CNTR_WIDTH-1:0] rd_value;
  logic [NUM_CH-1:0]     ovf;

  modport master (
    output inc_en, inc_ch, force_en, force_ch, force_value,
           chk_valid, chk_ch, chk_value, rd_ch,
    input  chk_done, chk_accept, rd_value, ovf
  );

  modport slave (
    input  inc_en, inc_ch, force_en, force_ch, force_value,
           chk_valid, chk_ch, chk_value, rd_ch,
    output chk_done, chk_accept, rd_value, ovf
  );
endinterface

// File: rtl/msg_counter_bank.sv
// Replay-protection counter bank: per-channel increment, force load and one-cycle freshness check.
// Optional exhaustion lock enabled by defining MSG_CNTR_LOCK_EN.
module msg_counter_bank #(
  parameter int CNTR_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter bit SATURATE   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  msg_counter_bank_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef logic [CNTR_WIDTH-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  function automatic logic in_range(input logic [CH_W-1:0] ch);
    return 32'(ch) < 32'(NUM_CH);
  endfunction

  // MSB of the result is the overflow indication.
  function automatic logic [CNTR_WIDTH:0] inc_next(input cnt_t c);
    if (c == CNT_MAX)
      return {1'b1, (SATURATE ? CNT_MAX : cnt_t'(0))};
    return {1'b0, c + cnt_t'(1)};
  endfunction

  cnt_t                cnt [NUM_CH];
  logic [CNTR_WIDTH:0] inc_res [NUM_CH];
  logic [NUM_CH-1:0]   ovf_q;
  logic [NUM_CH-1:0]   lock;
  logic [NUM_CH-1:0]   force_hit;
  logic [NUM_CH-1:0]   commit_hit;
  logic [NUM_CH-1:0]   inc_hit;
  logic                chk_acc;
  cnt_t                cnt_chk;
  cnt_t                rd_sel;
  logic                chk_done_p1;
  logic                chk_accept_p1;
  cnt_t                rd_value_p1;

`ifdef MSG_CNTR_LOCK_EN
  assign lock = ovf_q;
`else
  assign lock = '0;
`endif

  always_comb begin
    force_hit  = '0;
    commit_hit = '0;
    inc_hit    = '0;
    cnt_chk    = in_range(bus.chk_ch) ? cnt[bus.chk_ch] : '0;
    rd_sel     = in_range(bus.rd_ch)  ? cnt[bus.rd_ch]  : '0;
    // A force on the checked channel wins and voids the check.
    chk_acc    = bus.chk_valid && in_range(bus.chk_ch) && !lock[bus.chk_ch] &&
                 !(bus.force_en && (bus.force_ch == bus.chk_ch)) &&
                 (bus.chk_value > cnt_chk);
    for (int i = 0; i < NUM_CH; i++) begin
      force_hit[i]  = bus.force_en && (bus.force_ch == CH_W'(i));
      commit_hit[i] = chk_acc && (bus.chk_ch == CH_W'(i));
      inc_hit[i]    = bus.inc_en && (bus.inc_ch == CH_W'(i)) && !lock[i];
      inc_res[i]    = inc_next(cnt[i]);
    end
  end

  // Stage p1: counter update and registered check/read results.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf_q         <= '0;
      chk_done_p1   <= 1'b0;
      chk_accept_p1 <= 1'b0;
      rd_value_p1   <= '0;
    end else begin
      chk_done_p1   <= bus.chk_valid;
      chk_accept_p1 <= chk_acc;
      rd_value_p1   <= rd_sel;
      for (int i = 0; i < NUM_CH; i++) begin
        if (force_hit[i]) begin
          cnt[i]   <= bus.force_value;
          ovf_q[i] <= 1'b0;
        end else if (commit_hit[i]) begin
          cnt[i]   <= bus.chk_value;
        end else if (inc_hit[i]) begin
          cnt[i]   <= inc_res[i][CNTR_WIDTH-1:0];
          ovf_q[i] <= ovf_q[i] | inc_res[i][CNTR_WIDTH];
        end
      end
    end
  end

  // A result still pending when reset rises is suppressed before it can be seen.
  assign bus.chk_done   = chk_done_p1 & ~reset;
  assign bus.chk_accept = chk_accept_p1 & ~reset;
  assign bus.rd_value   = rd_value_p1;
  assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_msg_counter_bank.sv
// Directed bench for msg_counter_bank: a 4-channel wrapping bank and a 3-channel saturating bank.
module tb_msg_counter_bank;
`ifdef MSG_CNTR_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  msg_counter_bank_if #(.CNTR_WIDTH(32), .NUM_CH(4), .CH_W(2)) a ();
  msg_counter_bank_if #(.CNTR_WIDTH(32), .NUM_CH(3), .CH_W(2)) b ();

  msg_counter_bank #(.CNTR_WIDTH(32), .NUM_CH(4), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .bus(a.slave));
  msg_counter_bank #(.CNTR_WIDTH(32), .NUM_CH(3), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .bus(b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a.inc_en = 0; a.inc_ch = 0; a.force_en = 0; a.force_ch = 0; a.force_value = 0;
    a.chk_valid = 0; a.chk_ch = 0; a.chk_value = 0;
    b.inc_en = 0; b.inc_ch = 0; b.force_en = 0; b.force_ch = 0; b.force_value = 0;
    b.chk_valid = 0; b.chk_ch = 0; b.chk_value = 0;
  endtask

  task automatic rd_a(input logic [1:0] ch, output logic [31:0] v);
    a.rd_ch = ch;
    tick;
    v = a.rd_value;
  endtask

  task automatic rd_b(input logic [1:0] ch, output logic [31:0] v);
    b.rd_ch = ch;
    tick;
    v = b.rd_value;
  endtask

  task automatic test_reset;
    idle; a.rd_ch = 0; b.rd_ch = 0;
    reset = 1;
    tick; tick;
    total_cnt++; if (a.chk_done !== 1'b0) $display("FAIL reset_done: got %0b want 0", a.chk_done); else pass_cnt++;
    total_cnt++; if (a.chk_accept !== 1'b0) $display("FAIL reset_accept: got %0b want 0", a.chk_accept); else pass_cnt++;
    total_cnt++; if (a.rd_value !== 32'd0) $display("FAIL reset_rd: got %0h want 0", a.rd_value); else pass_cnt++;
    total_cnt++; if (a.ovf !== 4'b0) $display("FAIL reset_ovf: got %b want 0000", a.ovf); else pass_cnt++;
    reset = 0;
  endtask

  task automatic test_increment;
    logic [31:0] v;
    a.rd_ch = 1;
    a.inc_en = 1; a.inc_ch = 1;
    tick;
    total_cnt++; if (a.rd_value !== 32'd0) $display("FAIL inc_rd_preupdate: got %0d want 0", a.rd_value); else pass_cnt++;
    repeat (4) tick;
    idle;
    rd_a(1, v);
    total_cnt++; if (v !== 32'd5) $display("FAIL inc_cnt1: got %0d want 5", v); else pass_cnt++;
    rd_a(0, v);
    total_cnt++; if (v !== 32'd0) $display("FAIL inc_cnt0: got %0d want 0", v); else pass_cnt++;
    rd_a(2, v);
    total_cnt++; if (v !== 32'd0) $display("FAIL inc_cnt2: got %0d want 0", v); else pass_cnt++;
    total_cnt++; if (a.ovf !== 4'b0) $display("FAIL inc_ovf: got %b want 0000", a.ovf); else pass_cnt++;
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    a.force_en = 1; a.force_ch = 2; a.force_value = 32'hFFFF_FFFE;
    b.force_en = 1; b.force_ch = 2; b.force_value = 32'hFFFF_FFFE;
    tick;
    idle;
    a.inc_en = 1; a.inc_ch = 2; b.inc_en = 1; b.inc_ch = 2;
    tick; tick;
    idle;
    rd_a(2, v);
    total_cnt++; if (v !== 32'd0) $display("FAIL wrap_cnt2: got %0h want 0", v); else pass_cnt++;
    total_cnt++; if (a.ovf !== 4'b0100) $display("FAIL wrap_ovf: got %b want 0100", a.ovf); else pass_cnt++;
    rd_b(2, v);
    total_cnt++; if (v !== 32'hFFFF_FFFF) $display("FAIL sat_cnt2: got %0h want ffffffff", v); else pass_cnt++;
    total_cnt++; if (b.ovf !== 3'b100) $display("FAIL sat_ovf: got %b want 100", b.ovf); else pass_cnt++;
    b.inc_en = 1; b.inc_ch = 2;
    tick;
    idle;
    rd_b(2, v);
    total_cnt++; if (v !== 32'hFFFF_FFFF) $display("FAIL sat_hold: got %0h want ffffffff", v); else pass_cnt++;
    a.force_en = 1; a.force_ch = 2; a.force_value = 32'd7;
    tick;
    idle;
    total_cnt++; if (a.ovf !== 4'b0000) $display("FAIL force_clr_ovf: got %b want 0000", a.ovf); else pass_cnt++;
    rd_a(2, v);
    total_cnt++; if (v !== 32'd7) $display("FAIL force_cnt2: got %0d want 7", v); else pass_cnt++;
  endtask

  task automatic test_freshness;
    logic [31:0] vals [4];
    logic        exp  [4];
    logic [31:0] v;
    vals = '{32'd10, 32'd9, 32'd11, 32'd11};
    exp  = '{1'b0, 1'b0, 1'b1, 1'b0};
    a.force_en = 1; a.force_ch = 0; a.force_value = 32'd10;
    tick;
    idle;
    for (int i = 0; i < 4; i++) begin
      a.chk_valid = 1; a.chk_ch = 0; a.chk_value = vals[i];
      tick;
      total_cnt++; if (a.chk_done !== 1'b1) $display("FAIL fresh_done[%0d]: got %0b want 1", i, a.chk_done); else pass_cnt++;
      total_cnt++; if (a.chk_accept !== exp[i]) $display("FAIL fresh_accept[%0d]: got %0b want %0b", i, a.chk_accept, exp[i]); else pass_cnt++;
    end
    idle;
    tick;
    total_cnt++; if (a.chk_done !== 1'b0) $display("FAIL fresh_done_clear: got %0b want 0", a.chk_done); else pass_cnt++;
    rd_a(0, v);
    total_cnt++; if (v !== 32'd11) $display("FAIL fresh_cnt0: got %0d want 11", v); else pass_cnt++;
  endtask

  task automatic test_same_cycle;
    logic [31:0] v;
    a.force_en = 1; a.force_ch = 3; a.force_value = 32'd100;
    a.chk_valid = 1; a.chk_ch = 3; a.chk_value = 32'd200;
    a.inc_en = 1; a.inc_ch = 3;
    tick;
    idle;
    total_cnt++; if (a.chk_done !== 1'b1) $display("FAIL same_force_done: got %0b want 1", a.chk_done); else pass_cnt++;
    total_cnt++; if (a.chk_accept !== 1'b0) $display("FAIL same_force_accept: got %0b want 0", a.chk_accept); else pass_cnt++;
    rd_a(3, v);
    total_cnt++; if (v !== 32'd100) $display("FAIL same_force_cnt3: got %0d want 100", v); else pass_cnt++;
    a.inc_en = 1; a.inc_ch = 0;
    a.chk_valid = 1; a.chk_ch = 1; a.chk_value = 32'd50;
    tick;
    idle;
    total_cnt++; if (a.chk_accept !== 1'b1) $display("FAIL diff_ch_accept: got %0b want 1", a.chk_accept); else pass_cnt++;
    rd_a(0, v);
    total_cnt++; if (v !== 32'd12) $display("FAIL diff_ch_cnt0: got %0d want 12", v); else pass_cnt++;
    rd_a(1, v);
    total_cnt++; if (v !== 32'd50) $display("FAIL diff_ch_cnt1: got %0d want 50", v); else pass_cnt++;
    a.inc_en = 1; a.inc_ch = 1;
    a.chk_valid = 1; a.chk_ch = 1; a.chk_value = 32'd60;
    tick;
    idle;
    rd_a(1, v);
    total_cnt++; if (v !== 32'd60) $display("FAIL commit_over_inc: got %0d want 60", v); else pass_cnt++;
  endtask

  task automatic test_reset_inflight;
    logic [31:0] v;
    a.chk_valid = 1; a.chk_ch = 2; a.chk_value = 32'd20;
    tick;
    idle;
    reset = 1;
    #1;
    total_cnt++; if (a.chk_done !== 1'b0) $display("FAIL inflight_done: got %0b want 0", a.chk_done); else pass_cnt++;
    tick;
    total_cnt++; if (a.chk_done !== 1'b0) $display("FAIL inflight_done_post: got %0b want 0", a.chk_done); else pass_cnt++;
    reset = 0;
    for (int c = 0; c < 4; c++) begin
      rd_a(2'(c), v);
      total_cnt++; if (v !== 32'd0) $display("FAIL inflight_cnt%0d: got %0d want 0", c, v); else pass_cnt++;
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] v;
    b.chk_valid = 1; b.chk_ch = 3; b.chk_value = 32'd5;
    b.inc_en = 1; b.inc_ch = 3;
    tick;
    idle;
    total_cnt++; if (b.chk_done !== 1'b1) $display("FAIL oor_done: got %0b want 1", b.chk_done); else pass_cnt++;
    total_cnt++; if (b.chk_accept !== 1'b0) $display("FAIL oor_accept: got %0b want 0", b.chk_accept); else pass_cnt++;
    b.force_en = 1; b.force_ch = 3; b.force_value = 32'd9;
    tick;
    idle;
    rd_b(3, v);
    total_cnt++; if (v !== 32'd0) $display("FAIL oor_rd: got %0d want 0", v); else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      rd_b(2'(c), v);
      total_cnt++; if (v !== 32'd0) $display("FAIL oor_cnt%0d: got %0d want 0", c, v); else pass_cnt++;
    end
    total_cnt++; if (b.ovf !== 3'b000) $display("FAIL oor_ovf: got %b want 000", b.ovf); else pass_cnt++;
  endtask

  task automatic test_lock;
    logic [31:0] v;
    logic        exp_acc;
    logic [31:0] exp_cnt;
    exp_acc = LOCK ? 1'b0 : 1'b1;
    exp_cnt = LOCK ? 32'd0 : 32'd5;
    a.force_en = 1; a.force_ch = 1; a.force_value = 32'hFFFF_FFFF;
    tick;
    idle;
    a.inc_en = 1; a.inc_ch = 1;
    tick;
    idle;
    total_cnt++; if (a.ovf !== 4'b0010) $display("FAIL lock_ovf: got %b want 0010", a.ovf); else pass_cnt++;
    a.inc_en = 1; a.inc_ch = 1;
    a.chk_valid = 1; a.chk_ch = 1; a.chk_value = 32'd5;
    tick;
    idle;
    total_cnt++; if (a.chk_accept !== exp_acc) $display("FAIL lock_accept: got %0b want %0b", a.chk_accept, exp_acc); else pass_cnt++;
    rd_a(1, v);
    total_cnt++; if (v !== exp_cnt) $display("FAIL lock_cnt1: got %0d want %0d", v, exp_cnt); else pass_cnt++;
    a.force_en = 1; a.force_ch = 1; a.force_value = 32'd0;
    tick;
    idle;
    a.chk_valid = 1; a.chk_ch = 1; a.chk_value = 32'd5;
    tick;
    idle;
    total_cnt++; if (a.chk_accept !== 1'b1) $display("FAIL unlock_accept: got %0b want 1", a.chk_accept); else pass_cnt++;
    total_cnt++; if (a.ovf !== 4'b0000) $display("FAIL unlock_ovf: got %b want 0000", a.ovf); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1;
    test_reset;
    test_increment;
    test_overflow;
    test_freshness;
    test_same_cycle;
    test_reset_inflight;
    test_out_of_range;
    test_lock;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/msg_counter_bank.md
Name: msg_counter_bank

Overview:
Bank of NUM_CH independent message counters used for replay protection in the authentication datapath; each channel tracks the last accepted message sequence number.
- Supports per-channel increment and forced load.
- Provides a one-cycle freshness check: an incoming sequence number is accepted only if strictly greater than the stored value, and on accept it is committed.
- Handles overflow by wrap or saturate, with per-channel sticky overflow flags.

Parameters:
CNTR_WIDTH, 32, width of each counter and of all value ports
NUM_CH, 4, number of channels (>=1); CH_W = max(1,$clog2(NUM_CH)) derived internally
SATURATE, 0, 0 = wrap to 0 on overflow, 1 = hold at all-ones on overflow

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
inc_en  in  1  increment channel inc_ch this cycle
inc_ch  in  CH_W  increment channel index
force_en  in  1  load force_value into channel force_ch
force_ch  in  CH_W  force channel index
force_value  in  CNTR_WIDTH  value to load
chk_valid  in  1  freshness-check request
chk_ch  in  CH_W  channel to check
chk_value  in  CNTR_WIDTH  received sequence number
chk_done  out  1  one-cycle pulse, check result valid
chk_accept  out  1  1 = fresh (accepted and committed), valid only with chk_done
rd_ch  in  CH_W  read channel select
rd_value  out  CNTR_WIDTH  registered counter value of rd_ch
ovf  out  NUM_CH  sticky per-channel overflow flags

Behaviour:
- Reset (synchronous, high at a rising edge) has priority over everything:
  - all counters = 0, ovf = 0, chk_done = 0, chk_accept = 0, rd_value = 0.
  - A check in flight when reset asserts is dropped; no chk_done is produced.
- Per-channel update priority within one cycle is force > check-commit > increment. Operations on different channels in the same cycle all take effect.
- Force: cnt[force_ch] <= force_value; ovf[force_ch] <= 0.
- Increment when cnt != all-ones: cnt <= cnt + 1.
- Increment when cnt == all-ones:
  - SATURATE=0: cnt <= 0, ovf <= 1.
  - SATURATE=1: cnt unchanged, ovf <= 1.
- Check: evaluated against the pre-edge cnt[chk_ch]; the comparison is unsigned.
  - accept = (chk_value > cnt[chk_ch]).
  - On accept: cnt[chk_ch] <= chk_value. The increment on the same channel is dropped that cycle; no ovf change.
  - If force_en hits the same channel in the same cycle: accept is forced to 0 and there is no commit.
  - Result timing: chk_done = 1 and chk_accept registered on the edge following the request (latency 1); both return to 0 the next cycle unless a new request arrives.
  - Back-to-back checks every cycle are supported: throughput 1/cycle, no stall.
- Reject cases: chk_value == cnt is rejected (replayed message); chk_value < cnt is rejected.
- Read: rd_value <= cnt[rd_ch] as it stood before the same edge's update (latency 1, pre-update value).
- Out-of-range index (index >= NUM_CH):
  - inc and force are ignored.
  - A check returns chk_done = 1, chk_accept = 0.
  - A read returns 0.
- ovf bits are cleared only by reset or by a force on that channel.

Optional Feature:
MSG_CNTR_LOCK_EN: exhaustion lock.
- When defined, a channel whose ovf bit is set is locked:
  - increments are ignored;
  - checks return chk_accept = 0 with no commit;
  - force unlocks the channel (it clears ovf).
- When undefined, ovf is status only; the channel continues counting (wrap or saturate) and checks work normally.

Test Plan:
- Reset, then inc_en on ch1 for 5 cycles -> cnt1 = 5; rd_ch=1 -> rd_value = 5 one cycle later; other channels stay 0; ovf = 0.
- Force ch2 = 0xFFFFFFFE, then 2 increments -> SATURATE=0: cnt2 = 0 and ovf[2] = 1. SATURATE=1: cnt2 = 0xFFFFFFFF and ovf[2] = 1. A later force ch2 = 7 -> ovf[2] = 0.
- Force ch0 = 10, then checks with chk_value 10, 9, 11, 11 -> chk_accept = 0, 0, 1, 0 on consecutive cycles; final cnt0 = 11.
- Same cycle: force ch3 = 100, check ch3 with 200, inc ch3 -> cnt3 = 100, chk_done = 1, chk_accept = 0. Also same cycle: inc ch0 and check ch1 = 50 -> both applied.
- Reset asserted in the cycle after a chk_valid -> chk_done stays 0 and all counters read 0. With NUM_CH=3, a check on ch index 3 -> chk_done = 1, chk_accept = 0.
- With MSG_CNTR_LOCK_EN: overflow ch1, then inc and a check of 5 -> cnt1 unchanged, chk_accept = 0. Force ch1 = 0, then check 5 -> accepted.
